// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: polls the ps2_if FIFO, folds E0/F0/E1 prefixes into single key events.
// Optional typematic-repeat suppression: define PS2_DEC_REPEAT_FILTER_EN.
module ps2_key_decoder #(
    parameter int unsigned POLL_DIV       = 64,
    parameter int unsigned PREFIX_TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ps2_status,
    input  logic [31:0] ps2_data,
    output logic        ps2_rd,
    output logic [7:0]  key_code,
    output logic        key_ext,
    output logic        key_break,
    output logic        key_valid
);

    localparam int unsigned CNT_W = $clog2(POLL_DIV);
    localparam int unsigned TMO_W = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(PREFIX_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PFX,
        S_SKIP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] poll_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [2:0]       skip_cnt;
    logic             ext_flag;
    logic             brk_flag;

    logic       pop;
    logic [7:0] rx_byte;
    logic       is_prefix;
    logic       is_filler;
    logic       ev_fire;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;
    logic       emit;
    logic       unused_bits;

    assign unused_bits = ^{ps2_status[31:1], ps2_data[31:8]};

    // FWFT FIFO: the head byte is valid for the whole pop cycle and is consumed on its closing edge.
    assign pop       = (poll_cnt == POLL_LAST) && !ps2_status[0];
    assign ps2_rd    = pop;
    assign rx_byte   = ps2_data[7:0];
    assign is_prefix = rx_byte inside {8'hE0, 8'hF0, 8'hE1};
    assign is_filler = rx_byte inside {8'h00, 8'hAA, 8'hFC, 8'hFF};

    always_comb begin
        ev_fire = 1'b0;
        ev_code = rx_byte;
        ev_ext  = ext_flag;
        ev_brk  = brk_flag;
        if (pop) begin
            case (state)
                S_IDLE, S_PFX: ev_fire = !is_prefix && !is_filler;
                S_SKIP: begin
                    if (skip_cnt == 3'd1) begin
                        ev_fire = 1'b1;
                        ev_code = 8'h77;
                        ev_ext  = 1'b1;
                        ev_brk  = 1'b0;
                    end
                end
                default: ev_fire = 1'b0;
            endcase
        end
    end

`ifdef PS2_DEC_REPEAT_FILTER_EN
    logic [7:0] held_code;
    logic       held_ext;
    logic       held_vld;
    logic       held_match;

    assign held_match = held_vld && (held_code == ev_code) && (held_ext == ev_ext);
    assign emit       = ev_fire && !(held_match && !ev_brk);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_code <= '0;
            held_ext  <= 1'b0;
            held_vld  <= 1'b0;
        end else if (ev_fire) begin
            if (!ev_brk) begin
                held_code <= ev_code;
                held_ext  <= ev_ext;
                held_vld  <= 1'b1;
            end else if (held_match) begin
                held_vld <= 1'b0;
            end
        end
    end
`else
    assign emit = ev_fire;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            poll_cnt  <= '0;
            tmo_cnt   <= '0;
            skip_cnt  <= '0;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            key_code  <= '0;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            poll_cnt  <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + 1'b1;

            if (emit) begin
                key_code  <= ev_code;
                key_ext   <= ev_ext;
                key_break <= ev_brk;
                key_valid <= 1'b1;
            end

            // A captured byte always restarts the timeout, so capture beats a same-cycle expiry.
            if (pop) begin
                tmo_cnt <= '0;
                case (state)
                    S_IDLE: begin
                        case (rx_byte)
                            8'hE0: begin
                                ext_flag <= 1'b1;
                                state    <= S_PFX;
                            end
                            8'hF0: begin
                                brk_flag <= 1'b1;
                                state    <= S_PFX;
                            end
                            8'hE1: begin
                                skip_cnt <= 3'd7;
                                state    <= S_SKIP;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                    S_PFX: begin
                        case (rx_byte)
                            8'hE0: ext_flag <= 1'b1;
                            8'hF0: brk_flag <= 1'b1;
                            default: begin
                                ext_flag <= 1'b0;
                                brk_flag <= 1'b0;
                                state    <= S_IDLE;
                            end
                        endcase
                    end
                    S_SKIP: begin
                        skip_cnt <= skip_cnt - 3'd1;
                        if (skip_cnt == 3'd1) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE) begin
                if (tmo_cnt == TMO_LAST) begin
                    tmo_cnt  <= '0;
                    skip_cnt <= '0;
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                    state    <= S_IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule
